led_pattern_seq: RTL and testbench
==================================

Name: led_pattern_seq

Overview:
- Consumer-side stage for the board's free-running 50 MHz timebase: divides CLOCK_50 into a pattern step tick and drives the green LED bank with one of four animated patterns.
- A debounced pushbutton cycles the pattern mode; a PAUSE input freezes the animation.
- Sits between the raw board inputs (clock, KEY) and the LEDG pins.
- Replaces a fixed single-LED blink with a selectable display.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- STEP_HZ, 4, pattern step rate in Hz. DIV = CLK_HZ/STEP_HZ clock cycles per step; DIV must be >= 2.
- DEB_MS, 20, debounce window in ms. DEB_CYC = (CLK_HZ/1000)*DEB_MS.
- LEDS, 8, LED bank width; must be >= 2.

Ports:
- CLOCK_50  in   1     system clock; all logic is on its rising edge.
- RESET_N   in   1     asynchronous, active-low reset.
- KEY_MODE  in   1     raw pushbutton, active-low, asynchronous to the clock.
- PAUSE     in   1     synchronous level; high freezes stepping.
- LEDG      out  LEDS  LED pattern, registered.
- MODE      out  2     current mode, registered.
- STEP_TICK out  1     one-cycle pulse, high on each pattern step.

Behaviour:
- Reset (async assert, synchronous deassert handled by the board):
  - LEDG=0, MODE=0, STEP_TICK=0, prescaler=0, bounce direction=left.
  - Debounced key level=1 (released); sync flops=1.
- Prescaler:
  - Counts 0..DIV-1 while PAUSE=0.
  - On the edge where count==DIV-1: count->0, STEP_TICK<=1, LEDG<=next pattern, all on that same edge.
  - STEP_TICK is 0 in every other cycle.
  - First step lands DIV cycles after reset release.
  - While PAUSE=1: count holds its value, no steps occur, LEDG holds. Stepping resumes from the held count.
- Debounce (key_debounce):
  - KEY_MODE passes through a 2-flop synchroniser.
  - Debounced level changes only after DEB_CYC consecutive samples that differ from the current level. Any contrary sample clears the counter.
  - A 1->0 transition of the debounced level emits a one-cycle press pulse. Release emits nothing.
- Mode change on press pulse:
  - MODE<=MODE+1, wrapping 3->0.
  - On the same edge: LEDG<=init pattern of the new mode, prescaler<=0, direction<=left.
  - The next step therefore comes DIV cycles later.
  - Press and prescaler terminal count in the same cycle: press wins, the step is discarded, STEP_TICK=0.
  - Press is honoured while PAUSE=1: mode and pattern reload, prescaler is cleared and stays held at 0.
- Modes (next-pattern rules; init value in brackets):
  - 0 BLINK [all 0]: LEDG<=~LEDG.
  - 1 SHIFT [0x01]: rotate left by one; MSB wraps to LSB.
  - 2 BOUNCE [0x01, dir left]:
    - Moving left: shift left. If the result has the MSB set, dir<=right on the same edge.
    - Moving right: shift right. If the result is 0x01, dir<=left.
    - No dwell at either end.
  - 3 COUNT [0]: unsigned LEDG+1, modulo 2^LEDS.
- Reset asserted mid-operation immediately forces the reset values regardless of mode, pause or debounce state.

Decomposition:
- Shared package led_pkg:
  - Mode encodings MODE_BLINK=0, MODE_SHIFT=1, MODE_BOUNCE=2, MODE_COUNT=3.
  - Per-mode init-pattern function.
  - DIV and DEB_CYC derivation functions.
- One sub-module: key_debounce (synchroniser, stability counter, press-pulse output). It is reused for other KEY inputs.
- Prescaler and pattern logic stay in led_pattern_seq.

Test Plan:
Bench parameters: CLK_HZ=1000, STEP_HZ=100 (DIV=10), DEB_MS=5 (DEB_CYC=5), LEDS=8.
1. Reset and blink: hold RESET_N low, then release.
   - During reset: LEDG=0x00, MODE=0.
   - STEP_TICK at cycle 10 after release with LEDG=0xFF; cycle 20 gives 0x00; cycle 30 gives 0xFF.
2. Debounce and shift:
   - KEY_MODE low for 3 cycles -> MODE stays 0.
   - KEY_MODE low for 12 cycles -> exactly one press, MODE=1, LEDG=0x01.
   - Next 8 steps -> 0x02, 0x04, ..., 0x80, then 0x01.
3. Bounce: press into MODE=2 -> LEDG=0x01. Steps -> 0x02...0x80, 0x40...0x01, 0x02, with no repeated value at either end.
4. Count wrap and mode wrap:
   - MODE=3: 255 steps -> 0xFF; step 256 -> 0x00.
   - Press -> MODE=0, LEDG=0x00.
5. Pause and collision:
   - PAUSE high at prescaler=4 for 50 cycles -> no STEP_TICK, LEDG unchanged.
   - After PAUSE falls -> next STEP_TICK 6 cycles later.
   - Press pulse aligned with terminal count -> no STEP_TICK that cycle; next tick 10 cycles later.
6. Async reset mid-run: RESET_N low between clock edges while in MODE=2 with LEDG=0x20 -> LEDG=0x00 and MODE=0 before the next edge; after release, blink resumes as in scenario 1.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Clock cycles per pattern step.
  function automatic int calc_div(input int clk_hz, input int step_hz);
    return clk_hz / step_hz;
  endfunction

  // Consecutive contrary samples needed before the debounced level moves.
  function automatic int calc_deb_cyc(input int clk_hz, input int deb_ms);
    return (clk_hz / 1000) * deb_ms;
  endfunction

  // Every init pattern is zero except possibly bit 0: SHIFT and BOUNCE start
  // with a single lit LED at the LSB, BLINK and COUNT start dark.
  function automatic logic init_lsb(input mode_e m);
    return (m == MODE_SHIFT) || (m == MODE_BOUNCE);
  endfunction

  // Mode sequence wraps 3 -> 0 via natural 2-bit overflow.
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on the released->pressed transition. Generic over
// DEB_CYC so any active-low KEY input can use it.
module key_debounce #(
  parameter int DEB_CYC = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;

  // Bring the raw key into the clock domain; idle (released) level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Move the debounced level only after DEB_CYC contrary samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_cnt   <= '0;
          r_level <= r_sync2;
          // Only a fall of the level (key pressed) produces a pulse.
          r_press <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/led_pattern_seq.sv
// Green LED bank animator: prescaled step tick, four selectable patterns,
// debounced mode key and a pause input that freezes the animation.
module led_pattern_seq
  import led_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int STEP_HZ = 4,
  parameter int DEB_MS  = 20,
  parameter int LEDS    = 8
) (
  input  logic            CLOCK_50,
  input  logic            RESET_N,
  input  logic            KEY_MODE,
  input  logic            PAUSE,
  output logic [LEDS-1:0] LEDG,
  output logic [1:0]      MODE,
  output logic            STEP_TICK
);

  localparam int DIV     = calc_div(CLK_HZ, STEP_HZ);
  localparam int DEB_CYC = calc_deb_cyc(CLK_HZ, DEB_MS);
  localparam int PW      = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic            w_press;
  logic [LEDS-1:0] w_next_ledg;
  dir_e            w_next_dir;
  mode_e           w_new_mode;
  logic [LEDS-1:0] w_init_ledg;

  logic [LEDS-1:0] r_ledg;
  mode_e           r_mode;
  logic            r_tick;
  logic [PW-1:0]   r_pre;
  dir_e            r_dir;

  key_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_key_mode (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .i_key_n (KEY_MODE),
    .o_press (w_press)
  );

  assign w_new_mode  = next_mode(r_mode);
  assign w_init_ledg = {{(LEDS-1){1'b0}}, init_lsb(w_new_mode)};

  // Pattern (and bounce direction) that the next step would load.
  always_comb begin
    w_next_ledg = r_ledg;
    w_next_dir  = r_dir;
    case (r_mode)
      MODE_BLINK: w_next_ledg = ~r_ledg;
      MODE_SHIFT: w_next_ledg = {r_ledg[LEDS-2:0], r_ledg[LEDS-1]};
      MODE_BOUNCE: begin
        if (r_dir == DIR_LEFT) begin
          w_next_ledg = {r_ledg[LEDS-2:0], 1'b0};
          if (w_next_ledg[LEDS-1]) w_next_dir = DIR_RIGHT;
        end else begin
          w_next_ledg = {1'b0, r_ledg[LEDS-1:1]};
          if (w_next_ledg == LEDS'(1)) w_next_dir = DIR_LEFT;
        end
      end
      MODE_COUNT: w_next_ledg = r_ledg + LEDS'(1);
      default:    w_next_ledg = r_ledg;
    endcase
  end

  // Mode/prescaler state machine; a press outranks a coincident step.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ledg <= '0;
      r_mode <= MODE_BLINK;
      r_tick <= 1'b0;
      r_pre  <= '0;
      r_dir  <= DIR_LEFT;
    end else if (w_press) begin
      // Honoured even while paused; prescaler restarts so the next step is a
      // full DIV cycles away.
      r_mode <= w_new_mode;
      r_ledg <= w_init_ledg;
      r_pre  <= '0;
      r_dir  <= DIR_LEFT;
      r_tick <= 1'b0;
    end else if (!PAUSE && (r_pre == PRE_LAST)) begin
      r_pre  <= '0;
      r_tick <= 1'b1;
      r_ledg <= w_next_ledg;
      r_dir  <= w_next_dir;
    end else begin
      r_tick <= 1'b0;
      if (!PAUSE) r_pre <= r_pre + PW'(1);
    end
  end

  assign LEDG      = r_ledg;
  assign MODE      = r_mode;
  assign STEP_TICK = r_tick;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq with DIV=10, DEB_CYC=5, LEDS=8.
module tb_led_pattern_seq;

  localparam int DIV = 10;
  localparam int DEB = 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       key   = 1'b1;
  logic       pause = 1'b0;
  logic [7:0] ledg;
  logic [1:0] mode;
  logic       tick;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  led_pattern_seq #(
    .CLK_HZ  (1000),
    .STEP_HZ (100),
    .DEB_MS  (5),
    .LEDS    (8)
  ) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .KEY_MODE  (key),
    .PAUSE     (pause),
    .LEDG      (ledg),
    .MODE      (mode),
    .STEP_TICK (tick)
  );

  // ---------------- reference model ----------------
  // Pattern is a pure function of (mode, steps taken since mode entry).
  int m_mode, m_k, m_cnt, m_run;
  bit m_tick, m_s1, m_s2, m_lvl, m_press;

  function automatic logic [7:0] led_of(int md, int k);
    int p;
    case (md)
      0: return (k % 2 == 1) ? 8'hFF : 8'h00;
      1: return 8'(1 << (k % 8));
      2: begin
        p = k % 14;
        return 8'(1 << ((p < 8) ? p : 14 - p));
      end
      default: return 8'(k % 256);
    endcase
  endfunction

  task model_reset();
    m_mode = 0; m_k = 0; m_cnt = 0; m_tick = 0;
    m_s1 = 1; m_s2 = 1; m_lvl = 1; m_run = 0; m_press = 0;
  endtask

  task model_edge();
    bit np;
    if (m_press) begin
      m_mode = (m_mode + 1) % 4; m_k = 0; m_cnt = 0; m_tick = 0;
    end else if (!pause) begin
      if (m_cnt == DIV - 1) begin m_cnt = 0; m_tick = 1; m_k++; end
      else begin m_cnt++; m_tick = 0; end
    end else begin
      m_tick = 0;
    end
    np = 0;
    if (m_s2 != m_lvl) begin
      m_run++;
      if (m_run == DEB) begin m_lvl = m_s2; m_run = 0; np = !m_lvl; end
    end else begin
      m_run = 0;
    end
    m_press = np;
    m_s2 = m_s1;
    m_s1 = key;
  endtask

  task step_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wait_tick(output bit ok, output int n);
    ok = 0; n = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      step_cycle();
      n++;
      if (tick === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic key_press(int len);
    key = 1'b0;
    repeat (len) step_cycle();
    key = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] exp_led;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (ledg !== 8'h00) begin tests_failed++; $display("FAIL reset_ledg: got %h expected 00", ledg); end
    tests_run++;
    if (mode !== 2'd0) begin tests_failed++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    tests_run++;
    if (tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick: got %b expected 0", tick); end
    model_reset();
    rst_n = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step_cycle();
      tests_run++;
      if (ledg !== led_of(m_mode, m_k) || mode !== 2'(m_mode) || tick !== m_tick) begin
        tests_failed++;
        $display("FAIL blink_model cyc %0d: got led=%h mode=%0d tick=%b expected led=%h mode=%0d tick=%b",
                 c, ledg, mode, tick, led_of(m_mode, m_k), m_mode, m_tick);
      end
      if (c % 10 == 0) begin
        exp_led = (c == 20) ? 8'h00 : 8'hFF;
        tests_run++;
        if (tick !== 1'b1 || ledg !== exp_led) begin
          tests_failed++;
          $display("FAIL blink_step cyc %0d: got tick=%b led=%h expected tick=1 led=%h", c, tick, ledg, exp_led);
        end
      end
    end
  endtask

  task automatic test_debounce_shift();
    bit ok; int n; logic [7:0] exp_led;
    key_press(3);
    repeat (15) step_cycle();
    tests_run++;
    if (mode !== 2'd0) begin tests_failed++; $display("FAIL short_glitch_mode: got %0d expected 0", mode); end
    key_press(12);
    repeat (3) step_cycle();
    tests_run++;
    if (mode !== 2'd1 || ledg !== 8'h01) begin
      tests_failed++;
      $display("FAIL shift_entry: got mode=%0d led=%h expected mode=1 led=01", mode, ledg);
    end
    for (int i = 0; i < 8; i++) begin
      wait_tick(ok, n);
      exp_led = 8'(1 << ((i + 1) % 8));
      tests_run++;
      if (!ok || ledg !== exp_led || ledg !== led_of(m_mode, m_k)) begin
        tests_failed++;
        $display("FAIL shift_step %0d: got tick_seen=%b led=%h expected led=%h", i, ok, ledg, exp_led);
      end
    end
  endtask

  task automatic test_bounce();
    bit ok; int n;
    logic [7:0] tab [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                             8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    key_press(12);
    repeat (2) step_cycle();
    tests_run++;
    if (mode !== 2'd2 || ledg !== 8'h01) begin
      tests_failed++;
      $display("FAIL bounce_entry: got mode=%0d led=%h expected mode=2 led=01", mode, ledg);
    end
    for (int i = 0; i < 15; i++) begin
      wait_tick(ok, n);
      tests_run++;
      if (!ok || ledg !== tab[i]) begin
        tests_failed++;
        $display("FAIL bounce_step %0d: got tick_seen=%b led=%h expected led=%h", i, ok, ledg, tab[i]);
      end
    end
  endtask

  task automatic test_count_wrap();
    bit ok; int n;
    key_press(12);
    repeat (2) step_cycle();
    tests_run++;
    if (mode !== 2'd3 || ledg !== 8'h00) begin
      tests_failed++;
      $display("FAIL count_entry: got mode=%0d led=%h expected mode=3 led=00", mode, ledg);
    end
    for (int i = 1; i <= 256; i++) begin
      wait_tick(ok, n);
      tests_run++;
      if (!ok || ledg !== led_of(m_mode, m_k)) begin
        tests_failed++;
        $display("FAIL count_step %0d: got tick_seen=%b led=%h expected led=%h", i, ok, ledg, led_of(m_mode, m_k));
      end
      if (i == 255) begin
        tests_run++;
        if (ledg !== 8'hFF) begin tests_failed++; $display("FAIL count_255: got %h expected ff", ledg); end
      end
      if (i == 256) begin
        tests_run++;
        if (ledg !== 8'h00) begin tests_failed++; $display("FAIL count_wrap: got %h expected 00", ledg); end
      end
    end
    key_press(12);
    repeat (2) step_cycle();
    tests_run++;
    if (mode !== 2'd0 || ledg !== 8'h00) begin
      tests_failed++;
      $display("FAIL mode_wrap: got mode=%0d led=%h expected mode=0 led=00", mode, ledg);
    end
  endtask

  task automatic test_pause_collision();
    bit ok; int n; int ticks; bit changed; logic [7:0] held; int first;
    for (int i = 0; i < 2 * DIV && m_cnt != 4; i++) step_cycle();
    pause = 1'b1;
    held = led_of(m_mode, m_k);
    ticks = 0; changed = 0;
    repeat (50) begin
      step_cycle();
      if (tick === 1'b1) ticks++;
      if (ledg !== held) changed = 1;
    end
    tests_run++;
    if (ticks != 0 || changed) begin
      tests_failed++;
      $display("FAIL pause_hold: got ticks=%0d led_changed=%b expected ticks=0 led_changed=0", ticks, changed);
    end
    pause = 1'b0;
    wait_tick(ok, n);
    tests_run++;
    if (!ok || n != 6) begin
      tests_failed++;
      $display("FAIL pause_resume: got tick_seen=%b after %0d cycles expected after 6", ok, n);
    end
    // Press pulse lands on the edge where the prescaler is at terminal count.
    for (int i = 0; i < 2 * DIV && m_cnt != 2; i++) step_cycle();
    key = 1'b0;
    ticks = 0;
    for (int c = 1; c <= 8; c++) begin
      step_cycle();
      if (tick === 1'b1) ticks++;
    end
    tests_run++;
    if (ticks != 0 || mode !== 2'd1 || ledg !== 8'h01) begin
      tests_failed++;
      $display("FAIL collision: got ticks=%0d mode=%0d led=%h expected ticks=0 mode=1 led=01", ticks, mode, ledg);
    end
    first = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 4) key = 1'b1;
      step_cycle();
      if (tick === 1'b1 && first == 0) first = c;
    end
    tests_run++;
    if (first != 10) begin
      tests_failed++;
      $display("FAIL collision_next_tick: got cycle %0d expected 10", first);
    end
  endtask

  task automatic test_async_reset();
    bit ok; int n; bit reached; logic [7:0] exp_led;
    key_press(12);
    repeat (2) step_cycle();
    reached = 0;
    for (int i = 0; i < 8 && !reached; i++) begin
      wait_tick(ok, n);
      if (ledg === 8'h20) reached = 1;
    end
    tests_run++;
    if (!reached || mode !== 2'd2) begin
      tests_failed++;
      $display("FAIL async_setup: got mode=%0d led=%h expected mode=2 led=20", mode, ledg);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (ledg !== 8'h00 || mode !== 2'd0 || tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got led=%h mode=%0d tick=%b expected led=00 mode=0 tick=0", ledg, mode, tick);
    end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step_cycle();
      if (c % 10 == 0) begin
        exp_led = (c == 20) ? 8'h00 : 8'hFF;
        tests_run++;
        if (tick !== 1'b1 || ledg !== exp_led) begin
          tests_failed++;
          $display("FAIL post_reset_blink cyc %0d: got tick=%b led=%h expected tick=1 led=%h", c, tick, ledg, exp_led);
        end
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int s = 0; s < 200; s++) begin
      key   = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      pause = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      len   = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) begin
        step_cycle();
        tests_run++;
        if (ledg !== led_of(m_mode, m_k) || mode !== 2'(m_mode) || tick !== m_tick) begin
          tests_failed++;
          $display("FAIL random seg %0d: got led=%h mode=%0d tick=%b expected led=%h mode=%0d tick=%b",
                   s, ledg, mode, tick, led_of(m_mode, m_k), m_mode, m_tick);
        end
      end
    end
    key = 1'b1;
    pause = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_debounce_shift();
    test_bounce();
    test_count_wrap();
    test_pause_collision();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
